// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs, FSM states,
// ALU operation codes and datapath select codes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_OR  = 3'd1,
        ALU_ADD = 3'd2,
        ALU_SUB = 3'd6,
        ALU_SLT = 3'd7
    } alucontrol_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_aludec.sv
// ALU decoder: maps the FSM's aluop and the instruction funct field to alucontrol,
// flagging R-type functs the ALU does not implement.
module mips_multicycle_ctrl_aludec
    import mips_ctrl_pkg::*;
(
    input  aluop_e     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_illegal
);

    always_comb begin
        alucontrol    = ALU_ADD;
        funct_illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: begin
                        alucontrol    = ALU_AND;
                        funct_illegal = 1'b1;
                    end
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with req/ready memory handshake.
// Optional macro BNE_EN adds bne (op 000101) as an inverted-condition branch.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic               pcen,
    output logic [2:0]         alucontrol,
    output logic               illegal,
    output logic [STATE_W-1:0] dbg_state
);

    state_e state_q, state_d;
    aluop_e aluop;
    logic   funct_illegal;
    logic   pcwrite, branch, branch_taken;
    logic   mem_req_c, memwrite_c, irwrite_c, regwrite_c, illegal_c;

    mips_multicycle_ctrl_aludec u_aludec (
        .aluop        (aluop),
        .funct        (funct),
        .alucontrol   (alucontrol),
        .funct_illegal(funct_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

`ifdef BNE_EN
    // Remembers whether the branch being executed is bne, captured while op is decoded.
    logic bne_q, bne_d;

    always_comb begin
        bne_d = bne_q;
        if (state_q == S_DECODE) bne_d = (op == OP_BNE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bne_q <= 1'b0;
        else        bne_q <= bne_d;
    end

    assign branch_taken = zero ^ bne_q;
`else
    assign branch_taken = zero;
`endif

    always_comb begin
        state_d    = state_q;
        mem_req_c  = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        illegal_c  = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REGB;
        pcsrc      = PCSRC_ALU;
        aluop      = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                alusrcb   = SRCB_FOUR;
                if (mem_ready) begin
                    irwrite_c = 1'b1;
                    pcwrite   = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`else
                    OP_BNE: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
`endif
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c  = 1'b1;
                iord       = 1'b1;
                memwrite_c = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                if (funct_illegal) begin
                    illegal_c = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_ALUWB;
                end
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are masked by rst_n so an access is abandoned the instant reset asserts.
    assign mem_req   = mem_req_c & rst_n;
    assign memwrite  = memwrite_c & rst_n;
    assign irwrite   = irwrite_c & rst_n;
    assign regwrite  = regwrite_c & rst_n;
    assign illegal   = illegal_c & rst_n;
    assign pcen      = (pcwrite | (branch & branch_taken)) & rst_n;
    assign dbg_state = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven bench for mips_multicycle_ctrl: each row is one clock cycle of inputs and
// the outputs expected during that cycle, queued when driven and checked mid-cycle.
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] op = '0, funct = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] dbg_state;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol), .illegal(illegal), .dbg_state(dbg_state)
    );

    // strobe vector order: {mem_req, iord, memwrite, irwrite, regwrite, regdst, memtoreg, pcen, illegal}
    localparam logic [8:0] B_NONE  = 9'b000000000;
    localparam logic [8:0] B_FREQ  = 9'b100000000;
    localparam logic [8:0] B_FDONE = 9'b100100010;
    localparam logic [8:0] B_ILL   = 9'b000000001;
    localparam logic [8:0] B_MRD   = 9'b110000000;
    localparam logic [8:0] B_MWB   = 9'b000010100;
    localparam logic [8:0] B_MWR   = 9'b111000000;
    localparam logic [8:0] B_AWB   = 9'b000011000;
    localparam logic [8:0] B_PCEN  = 9'b000000010;
    localparam logic [8:0] B_IWB   = 9'b000010000;
    // select vector order: {alusrca, alusrcb[1:0], pcsrc[1:0]}
    localparam logic [4:0] X_F  = 5'b00100;
    localparam logic [4:0] X_D  = 5'b01100;
    localparam logic [4:0] X_MA = 5'b11000;
    localparam logic [4:0] X_0  = 5'b00000;
    localparam logic [4:0] X_EX = 5'b10000;
    localparam logic [4:0] X_BR = 5'b10001;
    localparam logic [4:0] X_J  = 5'b00010;
    localparam logic [3:0] A_DC = 4'b1000;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       rdy;
        logic [3:0] st;
        logic [8:0] strb;
        logic [4:0] sel;
        logic [3:0] alu;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic void row(input logic rst, input logic [5:0] o, input logic [5:0] f,
                                input logic z, input logic rdy, input logic [3:0] st,
                                input logic [8:0] strb, input logic [4:0] sel, input logic [3:0] alu);
        vec_t v;
        v.rst = rst; v.op = o; v.funct = f; v.zero = z; v.rdy = rdy;
        v.st = st; v.strb = strb; v.sel = sel; v.alu = alu;
        vecs.push_back(v);
    endfunction

    function automatic void fetch_decode(input logic [5:0] o, input logic [5:0] f);
        row(1, o, f, 0, 1, 4'd0, B_FDONE, X_F, 4'd2);
        row(1, o, f, 0, 1, 4'd1, B_NONE,  X_D, 4'd2);
    endfunction

    function automatic void rtype(input logic [5:0] f, input logic [3:0] alu);
        fetch_decode(OP_RTYPE, f);
        row(1, OP_RTYPE, f, 0, 1, 4'd6, B_NONE, X_EX, alu);
        row(1, OP_RTYPE, f, 0, 1, 4'd7, B_AWB,  X_0,  A_DC);
    endfunction

    function automatic void chk(input string name, input int idx, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endfunction

    initial begin
        // reset held with mem_ready high: strobes must stay masked
        row(0, 6'd0, 6'd0, 0, 1, 4'd0, B_NONE, X_F, 4'd2);
        row(0, 6'd0, 6'd0, 0, 1, 4'd0, B_NONE, X_F, 4'd2);
        rtype(FN_ADD, 4'd2);
        rtype(FN_SUB, 4'd6);
        rtype(FN_AND, 4'd0);
        rtype(FN_OR,  4'd1);
        rtype(FN_SLT, 4'd7);
        // lw with fetch stall and three MEMREAD wait cycles
        row(1, OP_LW, 6'd0, 0, 0, 4'd0, B_FREQ, X_F, 4'd2);
        fetch_decode(OP_LW, 6'd0);
        row(1, OP_LW, 6'd0, 0, 0, 4'd2, B_NONE, X_MA, 4'd2);
        for (int k = 0; k < 3; k++) row(1, OP_LW, 6'd0, 0, 0, 4'd3, B_MRD, X_0, A_DC);
        row(1, OP_LW, 6'd0, 0, 1, 4'd3, B_MRD, X_0, A_DC);
        row(1, OP_LW, 6'd0, 0, 1, 4'd4, B_MWB, X_0, A_DC);
        // beq taken then not taken
        fetch_decode(OP_BEQ, 6'd0);
        row(1, OP_BEQ, 6'd0, 1, 1, 4'd8, B_PCEN, X_BR, 4'd6);
        fetch_decode(OP_BEQ, 6'd0);
        row(1, OP_BEQ, 6'd0, 0, 1, 4'd8, B_NONE, X_BR, 4'd6);
        // sw with two wait cycles: memwrite for three cycles
        fetch_decode(OP_SW, 6'd0);
        row(1, OP_SW, 6'd0, 0, 0, 4'd2, B_NONE, X_MA, 4'd2);
        row(1, OP_SW, 6'd0, 0, 0, 4'd5, B_MWR, X_0, A_DC);
        row(1, OP_SW, 6'd0, 0, 0, 4'd5, B_MWR, X_0, A_DC);
        row(1, OP_SW, 6'd0, 0, 1, 4'd5, B_MWR, X_0, A_DC);
        row(1, OP_SW, 6'd0, 0, 0, 4'd0, B_FREQ, X_F, 4'd2);
        // addi and j
        fetch_decode(OP_ADDI, 6'd0);
        row(1, OP_ADDI, 6'd0, 0, 1, 4'd9,  B_NONE, X_MA, 4'd2);
        row(1, OP_ADDI, 6'd0, 0, 1, 4'd10, B_IWB,  X_0,  A_DC);
        fetch_decode(OP_J, 6'd0);
        row(1, OP_J, 6'd0, 0, 1, 4'd11, B_PCEN, X_J, A_DC);
        // illegal opcode, then illegal funct
        row(1, 6'h3F, 6'd0, 0, 1, 4'd0, B_FDONE, X_F, 4'd2);
        row(1, 6'h3F, 6'd0, 0, 1, 4'd1, B_ILL,   X_D, 4'd2);
        row(1, 6'h3F, 6'd0, 0, 0, 4'd0, B_FREQ,  X_F, 4'd2);
        fetch_decode(OP_RTYPE, 6'd0);
        row(1, OP_RTYPE, 6'd0, 0, 1, 4'd6, B_ILL,  X_EX, A_DC);
        row(1, OP_RTYPE, 6'd0, 0, 0, 4'd0, B_FREQ, X_F,  4'd2);
`ifdef BNE_EN
        fetch_decode(OP_BNE, 6'd0);
        row(1, OP_BNE, 6'd0, 0, 1, 4'd8, B_PCEN, X_BR, 4'd6);
        fetch_decode(OP_BNE, 6'd0);
        row(1, OP_BNE, 6'd0, 1, 1, 4'd8, B_NONE, X_BR, 4'd6);
`else
        row(1, OP_BNE, 6'd0, 0, 1, 4'd0, B_FDONE, X_F, 4'd2);
        row(1, OP_BNE, 6'd0, 0, 1, 4'd1, B_ILL,   X_D, 4'd2);
        row(1, OP_BNE, 6'd0, 0, 0, 4'd0, B_FREQ,  X_F, 4'd2);
`endif
        // reset asserted mid-cycle during a MEMWRITE wait, then a clean restart
        fetch_decode(OP_SW, 6'd0);
        row(1, OP_SW, 6'd0, 0, 0, 4'd2, B_NONE, X_MA, 4'd2);
        row(1, OP_SW, 6'd0, 0, 0, 4'd5, B_MWR, X_0, A_DC);
        row(0, OP_SW, 6'd0, 0, 0, 4'd0, B_NONE, X_F, 4'd2);
        row(0, OP_SW, 6'd0, 0, 1, 4'd0, B_NONE, X_F, 4'd2);
        rtype(FN_ADD, 4'd2);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t e;
            @(posedge clk);
            #1;
            rst_n     = vecs[i].rst;
            op        = vecs[i].op;
            funct     = vecs[i].funct;
            zero      = vecs[i].zero;
            mem_ready = vecs[i].rdy;
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard vec %0d: got empty queue expected entry", i);
                continue;
            end
            e = exp_q.pop_front();
            $display("vec %0d rst_n=%0b op=%02h funct=%02h z=%0b rdy=%0b -> state=%0d strb=%03h sel=%02h alu=%0d",
                     i, rst_n, op, funct, zero, mem_ready, dbg_state,
                     {mem_req, iord, memwrite, irwrite, regwrite, regdst, memtoreg, pcen, illegal},
                     {alusrca, alusrcb, pcsrc}, alucontrol);
            chk("state", i, {5'd0, dbg_state}, {5'd0, e.st});
            chk("strobes", i, {mem_req, iord, memwrite, irwrite, regwrite, regdst, memtoreg, pcen, illegal}, e.strb);
            chk("selects", i, {4'd0, alusrca, alusrcb, pcsrc}, {4'd0, e.sel});
            if (!e.alu[3]) chk("alucontrol", i, {6'd0, alucontrol}, {6'd0, e.alu[2:0]});
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
